mem_wb_stage: RTL and testbench

//  Pipeline MEM stage plus the MEM/WB register feeding the write-back mux.

---
 rtl/riscv_pkg.sv | 9 +
 rtl/lsu_align.sv | 29 ++
 rtl/mem_wb_stage.sv | 78 +++++++
 tb/tb_mem_wb_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared load/store funct3 codes and MEM-stage FSM states
package riscv_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, REQ, RESP} mem_state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane replication/byte enables, load extract/extend, misalignment detect
module lsu_align import riscv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic            is_store,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] st_data,
  output logic [XLEN-1:0] ld_data,
  output logic            misalign
);
  logic [XLEN-1:0] sh;
  always_comb begin
    sh = rdata >> {addr_lo, 3'b000};
    misalign = (funct3[1:0] == 2'b01 & addr_lo[0]) | (funct3[1:0] == 2'b10 & addr_lo != 2'b00);
    be = !is_store ? 4'b1111 :
         funct3[1:0] == 2'b00 ? 4'b0001 << addr_lo :
         funct3[1:0] == 2'b01 ? 4'b0011 << addr_lo : 4'b1111;
    st_data = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
              funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
    ld_data = funct3 == F3_B  ? XLEN'($signed(sh[7:0])) :
              funct3 == F3_H  ? XLEN'($signed(sh[15:0])) :
              funct3 == F3_BU ? XLEN'(sh[7:0]) :
              funct3 == F3_HU ? XLEN'(sh[15:0]) : sh;
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage with dmem valid/ready handshake and MEM/WB register
module mem_wb_stage import riscv_pkg::*; #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_M,
  input  logic              mem_read_M,
  input  logic              mem_write_M,
  input  logic              mem_to_reg_M,
  input  logic              reg_we_M,
  input  logic [4:0]        rd_M,
  input  logic [2:0]        funct3_M,
  input  logic [XLEN-1:0]   ALU_out_M,
  input  logic [XLEN-1:0]   wdata_M,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_rsp_valid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              stall_M,
  output logic              misalign_M,
  output logic              mem_to_reg_W,
  output logic              reg_we_W,
  output logic [4:0]        rd_W,
  output logic [XLEN-1:0]   ALU_out_W,
  output logic [XLEN-1:0]   d_out_W
);
  mem_state_t state;
  logic mem_op, mis, access, done, complete;
  logic [XLEN-1:0] ld_data;
  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3(funct3_M),
    .addr_lo(ALU_out_M[1:0]),
    .is_store(mem_write_M),
    .wdata(wdata_M),
    .rdata(dmem_rdata),
    .be(dmem_be),
    .st_data(dmem_wdata),
    .ld_data(ld_data),
    .misalign(mis)
  );
  // Request fields come straight from EX/MEM, which the stall holds stable.
  always_comb begin
    mem_op = mem_read_M | mem_write_M;
    access = ~rst & valid_M & mem_op & ~mis;
    done = state == RESP & dmem_rsp_valid;
    complete = valid_M & (~mem_op | (access & done));
    dmem_req_valid = access & state != RESP;
    stall_M = access & ~done;
    misalign_M = ~rst & valid_M & mem_op & mis;
  end
  assign dmem_we = mem_write_M;
  assign dmem_addr = {ALU_out_M[ADDR_W-1:2], 2'b00};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mem_to_reg_W <= 1'b0;
      reg_we_W <= 1'b0;
      rd_W <= '0;
      ALU_out_W <= '0;
      d_out_W <= '0;
    end else begin
      state <= state == IDLE ? (access ? (dmem_req_ready ? RESP : REQ) : IDLE) :
               state == REQ  ? (dmem_req_ready ? RESP : REQ) :
               (dmem_rsp_valid ? IDLE : RESP);
      mem_to_reg_W <= complete & mem_to_reg_M;
      reg_we_W <= complete & reg_we_M;
      rd_W <= complete ? rd_M : '0;
      ALU_out_W <= complete ? ALU_out_M : '0;
      d_out_W <= complete & mem_read_M ? ld_data : '0;
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed vectors checked against a behavioural MEM/WB model
module tb_mem_wb_stage;
  logic clk = 0, rst = 1;
  logic valid = 0, rd_en = 0, wr_en = 0, m2r = 0, we = 0;
  logic [4:0] rd = 0;
  logic [2:0] f3 = 0;
  logic [31:0] alu = 0, wd = 0, rdata = 0;
  logic ready = 0, rsp = 0;
  logic req_v, d_we, stall, mis, m2r_w, we_w;
  logic [31:0] d_addr, d_wdata, alu_w, dout_w;
  logic [3:0] d_be;
  logic [4:0] rd_w;
  int checks = 0, errors = 0;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .valid_M(valid), .mem_read_M(rd_en), .mem_write_M(wr_en),
    .mem_to_reg_M(m2r), .reg_we_M(we), .rd_M(rd), .funct3_M(f3), .ALU_out_M(alu),
    .wdata_M(wd), .dmem_req_valid(req_v), .dmem_req_ready(ready), .dmem_we(d_we),
    .dmem_addr(d_addr), .dmem_wdata(d_wdata), .dmem_be(d_be), .dmem_rsp_valid(rsp),
    .dmem_rdata(rdata), .stall_M(stall), .misalign_M(mis), .mem_to_reg_W(m2r_w),
    .reg_we_W(we_w), .rd_W(rd_w), .ALU_out_W(alu_w), .d_out_W(dout_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic misal(input logic [2:0] f, input logic [1:0] a);
    return (f[1:0] == 2'd1 && a[0]) || (f[1:0] == 2'd2 && a != 2'd0);
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * a);
    case (f)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input logic st, input logic [2:0] f, input logic [1:0] a);
    if (!st || f[1:0] == 2'd2) return 4'hF;
    return f[1:0] == 2'd0 ? 4'(1 << a) : 4'(3 << a);
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] f, input logic [31:0] w);
    if (f[1:0] == 2'd0) return {w[7:0], w[7:0], w[7:0], w[7:0]};
    if (f[1:0] == 2'd1) return {w[15:0], w[15:0]};
    return w;
  endfunction

  // Model: "acc" means a request has been accepted and its response is awaited.
  logic acc = 0, e_wb = 0, e_we = 0, e_m2r = 0, e_ld = 0;
  logic [4:0] e_rd = 0;
  logic [31:0] e_alu = 0, e_dout = 0;
  logic p_live, p_done;

  always @(posedge clk) begin
    if (rst) begin
      acc = 0; e_wb = 0; e_we = 0; e_m2r = 0; e_ld = 0;
    end else begin
      p_live = valid && (rd_en || wr_en) && !misal(f3, alu[1:0]);
      p_done = valid && (!(rd_en || wr_en) || (p_live && acc && rsp));
      e_wb = p_done; e_we = p_done && we; e_m2r = p_done && m2r; e_ld = p_done && rd_en;
      e_rd = rd; e_alu = alu; e_dout = load_val(f3, alu[1:0], rdata);
      if (p_live && !acc && ready) acc = 1;
      else if (acc && rsp) acc = 0;
    end
  end

  always @(negedge clk) begin
    logic live, memop;
    memop = rd_en || wr_en;
    live = !rst && valid && memop && !misal(f3, alu[1:0]);
    chk("stall_M", 32'(stall), 32'(live && !(acc && rsp)));
    chk("dmem_req_valid", 32'(req_v), 32'(live && !acc));
    chk("misalign_M", 32'(mis), 32'(!rst && valid && memop && misal(f3, alu[1:0])));
    if (live && !acc) begin
      chk("dmem_addr", d_addr, {alu[31:2], 2'b00});
      chk("dmem_we", 32'(d_we), 32'(wr_en));
      chk("dmem_be", 32'(d_be), 32'(exp_be(wr_en, f3, alu[1:0])));
      if (wr_en) chk("dmem_wdata", d_wdata, exp_wd(f3, wd));
    end
    chk("reg_we_W", 32'(we_w), 32'(e_we));
    chk("mem_to_reg_W", 32'(m2r_w), 32'(e_m2r));
    if (e_wb) begin
      chk("rd_W", 32'(rd_w), 32'(e_rd));
      chk("ALU_out_W", alu_w, e_alu);
    end
    if (e_ld) chk("d_out_W", dout_w, e_dout);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic r, input logic w, input logic mr, input logic e,
                        input logic [4:0] d, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] wv);
    valid = 1; rd_en = r; wr_en = w; m2r = mr; we = e; rd = d; f3 = f; alu = a; wd = wv;
  endtask

  // Runs one memory op: n_rdy cycles with ready low, accept, n_rsp waits, then response.
  task automatic run_mem(input int n_rdy, input int n_rsp, input logic [31:0] x_addr,
                         input logic [3:0] x_be, input logic [31:0] x_wd, output int stalls);
    stalls = 0;
    for (int i = 0; i <= n_rdy + n_rsp + 1; i++) begin
      ready = (i == n_rdy);
      rsp = (i == n_rdy + n_rsp + 1);
      @(negedge clk);
      if (stall) stalls++;
      if (req_v) begin
        chk("req_addr_lit", d_addr, x_addr);
        chk("req_be_lit", 32'(d_be), 32'(x_be));
        if (wr_en) chk("req_wdata_lit", d_wdata, x_wd);
      end
      tick();
    end
    ready = 0; rsp = 0; valid = 0;
  endtask

  int ns;

  initial begin
    tick(); tick();
    rst = 0;
    chk("reset_reg_we_W", 32'(we_w), 0);
    chk("reset_stall", 32'(stall), 0);
    // ADD
    set_op(0, 0, 0, 1, 5'd3, 3'b000, 32'h55, 0);
    tick();
    valid = 0;
    chk("add_rd_W", 32'(rd_w), 3);
    chk("add_reg_we_W", 32'(we_w), 1);
    chk("add_ALU_out_W", alu_w, 32'h55);
    tick();
    chk("add_bubble", 32'(we_w), 0);
    // LB / LBU
    rdata = 32'h80FF_1234;
    set_op(1, 0, 1, 1, 5'd5, 3'b000, 32'h102, 0);
    run_mem(0, 2, 32'h100, 4'hF, 0, ns);
    chk("lb_stall_cycles", 32'(ns), 3);
    chk("lb_d_out_W", dout_w, 32'hFFFF_FFFF);
    set_op(1, 0, 1, 1, 5'd6, 3'b100, 32'h102, 0);
    run_mem(0, 2, 32'h100, 4'hF, 0, ns);
    chk("lbu_d_out_W", dout_w, 32'h0000_00FF);
    // LH / LHU at upper half
    set_op(1, 0, 1, 1, 5'd7, 3'b001, 32'h102, 0);
    run_mem(1, 0, 32'h100, 4'hF, 0, ns);
    chk("lh_d_out_W", dout_w, 32'hFFFF_80FF);
    set_op(1, 0, 1, 1, 5'd7, 3'b101, 32'h102, 0);
    run_mem(0, 0, 32'h100, 4'hF, 0, ns);
    chk("lhu_d_out_W", dout_w, 32'h0000_80FF);
    // SH with ready held low
    set_op(0, 1, 0, 0, 5'd0, 3'b001, 32'h206, 32'hDEAD_BEEF);
    run_mem(2, 1, 32'h204, 4'b1100, 32'hBEEF_BEEF, ns);
    chk("sh_stall_cycles", 32'(ns), 4);
    chk("sh_reg_we_W", 32'(we_w), 0);
    // SB to top byte, SW
    set_op(0, 1, 0, 0, 5'd0, 3'b000, 32'h203, 32'h1234_56EF);
    run_mem(0, 0, 32'h200, 4'b1000, 32'hEFEF_EFEF, ns);
    set_op(0, 1, 0, 0, 5'd0, 3'b010, 32'h208, 32'hCAFE_F00D);
    run_mem(1, 1, 32'h208, 4'b1111, 32'hCAFE_F00D, ns);
    // LW misaligned
    set_op(1, 0, 1, 1, 5'd9, 3'b010, 32'h103, 0);
    @(negedge clk);
    chk("mis_pulse", 32'(mis), 1);
    chk("mis_no_req", 32'(req_v), 0);
    chk("mis_no_stall", 32'(stall), 0);
    tick();
    valid = 0;
    chk("mis_bubble", 32'(we_w), 0);
    @(negedge clk);
    chk("mis_one_cycle", 32'(mis), 0);
    tick();
    // Reset while in RESP, then a late response
    set_op(1, 0, 1, 1, 5'd4, 3'b010, 32'h300, 0);
    ready = 1;
    tick();
    ready = 0;
    rst = 1;
    tick();
    rst = 0; valid = 0; rsp = 1;
    chk("rst_req", 32'(req_v), 0);
    chk("rst_reg_we_W", 32'(we_w), 0);
    tick();
    rsp = 0;
    chk("late_rsp_no_wb", 32'(we_w), 0);
    chk("late_rsp_no_m2r", 32'(m2r_w), 0);
    // Back-to-back ADD after the abandoned access
    set_op(0, 0, 0, 1, 5'd12, 3'b000, 32'hABCD, 0);
    tick();
    valid = 0;
    chk("post_rst_add", alu_w, 32'hABCD);
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
